dmem_dump_reader: RTL and testbench
===================================

# dmem_dump_reader

Sequential reader for the 32x32 data memory: on a start pulse it walks every word of the memory, issues one read per word, and streams each word out on a valid/ready port in ascending address order. It is the read-back counterpart of the file loader that fills instruction memory. It sits beside the processor on the data-memory bus and takes ownership of that bus while busy, so the bench can dump the final data memory after a program has run.

## Interface
- `DEPTH`, 32, number of words dumped.
- `DATA_W`, 32, word width.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0.
- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  reset, synchronous and active-low.
- `Start`  in  1  one-cycle request to begin a dump; ignored unless the state is IDLE or DONE.
- `MemRead`  out  1  read strobe to the data memory.
- `Address`  out  32  byte address to the data memory: `BASE_ADDR + 4*index`.
- `ReadData`  in  DATA_W  data-memory output, valid one cycle after `MemRead`.
- `DataOut`  out  DATA_W  dumped word.
- `DataOut_valid`  out  1  `DataOut` and `Word_index` are valid.
- `DataOut_ready`  in  1  consumer accepts the word.
- `Word_index`  out  5  index of the word on `DataOut`.
- `Busy`  out  1  the block owns the memory bus; the processor's memory strobes must be masked.
- `Done`  out  1  all `DEPTH` words have been accepted; held until the next `Start` or reset.
- `Checksum`  out  DATA_W  running checksum (see Configuration).

## Operation
- The FSM has five states: IDLE, ISSUE, WAIT, HOLD, DONE.
- **IDLE/DONE + Start** -> ISSUE. On this transition: index=0, `Done`=0, checksum=0.
- **ISSUE**
  - `MemRead`=1 and `Address`=`BASE_ADDR+{index,2'b00}`.
  - Next state is WAIT.
- **WAIT**
  - Register `ReadData` into `DataOut` and `index` into `Word_index`.
  - Next state is HOLD.
- **HOLD**
  - `DataOut_valid`=1. `DataOut` and `Word_index` stay stable until `DataOut_valid && DataOut_ready`.
  - On acceptance: if index==DEPTH-1, go to DONE; otherwise index+1 and go to ISSUE.
- **DONE**: `Done`=1 and `Busy`=0.
- `Busy`=1 in ISSUE, WAIT and HOLD.
- `MemRead` is 0 outside ISSUE. The block never writes memory.
- The index counter is 5 bits. Because the terminal test is index==DEPTH-1, it never wraps.
- A `Start` pulse during ISSUE, WAIT or HOLD is dropped. It is not queued.
- If `DataOut_ready` is already high when HOLD is entered, the word is accepted in HOLD's first cycle.

## Timing
- Reset values, applied when `Rst`=0 at a rising edge:
  - State is IDLE.
  - All outputs are 0, including `Address`, `DataOut`, `Word_index` and `Checksum`.
- Reset asserted mid-dump aborts immediately. No further `MemRead` is issued and `Done` stays 0.
- Latency from the `Start` edge:
  - `MemRead` at cycle +1.
  - First `DataOut_valid` at cycle +3.
- Throughput is 1 word per 3 cycles when `DataOut_ready` is held high. A full dump then takes 96 cycles from ISSUE to DONE.
- Backpressure adds cycles only in HOLD. The memory is not re-read while waiting.

## Configuration
- **`DUMP_CHECKSUM_EN` defined**
  - On each accepted word, `Checksum <= {Checksum[DATA_W-2:0],Checksum[DATA_W-1]} ^ DataOut`.
  - The checksum is valid when `Done` rises and holds until the next `Start`.
- **Not defined**
  - `Checksum` is tied to 0.
  - No accumulator register is synthesised.
  - All other behaviour is identical.

## Structure
- Shared package `riscv_lite_pkg` holds:
  - The state encoding typedef `dump_state_t` (IDLE=0, ISSUE=1, WAIT=2, HOLD=3, DONE=4).
  - `WORD_BYTES`=4.
  - `DMEM_DEPTH`=32.
- One natural sub-module is `dump_checksum`: rotate-XOR accumulator with clear/enable inputs. It is instantiated only under `DUMP_CHECKSUM_EN`.
- Everything else lives in the top module: FSM, index counter, output registers.

## Test plan
- **Reset:** hold `Rst`=0 for 2 cycles with `Start`=1 -> all outputs 0, no `MemRead`.
- **Full dump:**
  - Stimulus: memory preloaded with word[i]=32'hA5A5_0000+i, `DataOut_ready`=1, `Start` pulse.
  - Response: 32 words in order, index 0..31, `Address` 0x00..0x7C, `Done`=1 at the 97th cycle after `Start`.
- **Backpressure:** `DataOut_ready`=0 for 5 cycles on word 7 -> `DataOut`=32'hA5A5_0007 stable and no extra `MemRead` while stalled; word 8 follows normally.
- **Start while busy:** `Start` pulses at words 3 and 10 -> dump is unaffected and exactly 32 words are emitted.
- **Reset mid-dump and restart:**
  - `Rst`=0 during word 15 -> IDLE, `Done`=0.
  - A new `Start` -> dump restarts at index 0.
- **Checksum (`DUMP_CHECKSUM_EN`):** all words 32'h0000_0001 -> `Checksum`=32'hFFFF_FFFF at `Done`. Without the macro, `Checksum`=0 throughout.

Source files
------------

// File: rtl/riscv_lite_pkg.sv
// riscv_lite_pkg: shared state encoding and memory geometry for the riscv_lite blocks
package riscv_lite_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } dump_state_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam int DMEM_DEPTH = 32;
endpackage

// File: rtl/dump_checksum.sv
// dump_checksum: rotate-left-by-one then XOR accumulator with synchronous clear and enable
module dump_checksum #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sum
);
  logic [W-1:0] r_sum;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sum <= '0;
    else if (i_clr) r_sum <= '0;
    else if (i_en) r_sum <= {r_sum[W-2:0], r_sum[W-1]} ^ i_data;
  end
  assign o_sum = r_sum;
endmodule

// File: rtl/dmem_dump_reader.sv
// dmem_dump_reader: walks the data memory once per Start and streams every word out on a valid/ready port
// Optional running checksum enabled by defining DUMP_CHECKSUM_EN; otherwise Checksum is tied to 0.
module dmem_dump_reader
  import riscv_lite_pkg::*;
#(
  parameter int          DEPTH     = DMEM_DEPTH,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic              MemRead,
  output logic [31:0]       Address,
  input  logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataOut_valid,
  input  logic              DataOut_ready,
  output logic [4:0]        Word_index,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Checksum
);
  dump_state_t       r_state, w_next;
  logic [4:0]        r_index, r_widx;
  logic [DATA_W-1:0] r_data;
  logic              w_start, w_accept, w_last;
  assign w_start  = Start && (r_state == IDLE || r_state == DONE);
  assign w_accept = r_state == HOLD && DataOut_ready;
  assign w_last   = r_index == 5'(DEPTH - 1);
  always_ff @(posedge Clk) begin
    if (!Rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_start ? ISSUE : r_state;
      ISSUE:      w_next = WAIT;
      WAIT:       w_next = HOLD;
      HOLD:       w_next = w_accept ? (w_last ? DONE : ISSUE) : HOLD;
      default:    w_next = IDLE;
    endcase
  end
  always_comb begin
    MemRead       = r_state == ISSUE;
    Address       = MemRead ? BASE_ADDR + 32'(r_index) * WORD_BYTES : '0;
    DataOut_valid = r_state == HOLD;
    Busy          = r_state == ISSUE || r_state == WAIT || r_state == HOLD;
    Done          = r_state == DONE;
  end
  // the terminal compare stops the index at DEPTH-1, so it never wraps
  always_ff @(posedge Clk) begin
    if (!Rst) r_index <= '0;
    else if (w_start) r_index <= '0;
    else if (w_accept && !w_last) r_index <= r_index + 5'd1;
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_data <= '0;
      r_widx <= '0;
    end else if (r_state == WAIT) begin
      r_data <= ReadData;
      r_widx <= r_index;
    end
  end
  assign DataOut    = r_data;
  assign Word_index = r_widx;
`ifdef DUMP_CHECKSUM_EN
  dump_checksum #(.W(DATA_W)) u_checksum (
    .i_clk  (Clk),
    .i_rst_n(Rst),
    .i_clr  (w_start),
    .i_en   (w_accept),
    .i_data (r_data),
    .o_sum  (Checksum)
  );
`else
  assign Checksum = '0;
`endif
endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb_dmem_dump_reader: directed and randomized dumps checked against a word-level reference of the dump rules
module tb_dmem_dump_reader;
  logic        Clk = 0, Rst = 0, Start = 0, DataOut_ready = 0;
  logic        MemRead, DataOut_valid, Busy, Done;
  logic [31:0] Address, ReadData = 0, DataOut, Checksum;
  logic [4:0]  Word_index;
  logic [31:0] mem [32];
  int tests = 0, fails = 0;

  dmem_dump_reader dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .MemRead(MemRead), .Address(Address),
    .ReadData(ReadData), .DataOut(DataOut), .DataOut_valid(DataOut_valid),
    .DataOut_ready(DataOut_ready), .Word_index(Word_index), .Busy(Busy),
    .Done(Done), .Checksum(Checksum)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) if (MemRead) ReadData <= mem[Address[6:2]];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_memread"}, 32'(MemRead), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_valid"}, 32'(DataOut_valid), 0);
  endtask

  function automatic logic [31:0] ck_step(input logic [31:0] c, input logic [31:0] w);
    return {c[30:0], c[31]} ^ w;
  endfunction

  function automatic logic [31:0] ck_expect(input logic [31:0] model);
`ifdef DUMP_CHECKSUM_EN
    return model;
`else
    return model & 32'h0;
`endif
  endfunction

  task automatic run_dump(input int stall_word, input int stall_len, input bit rnd_ready,
                          input bit busy_starts, input int abort_at);
    int cyc = 1, nrd = 0, nacc = 0, stalls = 0, vcnt = 0, done_cyc = 0;
    bit seen = 0;
    logic [31:0] ck = 0;
    Start = 1;
    tick();
    Start = 0;
    chk("memread_latency", 32'(MemRead), 1);
    while (cyc < 600) begin
      Start = 0;
      if (MemRead) begin
        chk("address", Address, 32'(nrd) * 4);
        chk("busy_issue", 32'(Busy), 1);
        nrd++;
      end
      if (DataOut_valid) begin
        if (!seen) chk("valid_latency", 32'(cyc), 3);
        seen = 1;
        chk("data", DataOut, mem[nacc[4:0]]);
        chk("index", 32'(Word_index), 32'(nacc));
        if (nacc == abort_at) begin
          Rst = 0;
          tick();
          chk_idle("abort");
          chk("abort_data", DataOut, 0);
          Rst = 1;
          repeat (3) begin
            tick();
            chk_idle("after_abort");
          end
          return;
        end
        if (busy_starts && vcnt == 0 && (nacc == 3 || nacc == 10)) Start = 1;
        DataOut_ready = rnd_ready ? 1'($urandom_range(0, 1))
                                  : !(nacc == stall_word && vcnt < stall_len);
        if (DataOut_ready) begin
          ck = ck_step(ck, mem[nacc[4:0]]);
          nacc++;
          vcnt = 0;
        end else begin
          stalls++;
          vcnt++;
        end
      end else DataOut_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (Done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    chk("words_accepted", 32'(nacc), 32);
    chk("reads_issued", 32'(nrd), 32);
    chk("done_cycle", 32'(done_cyc), 32'(97 + stalls));
    chk("busy_at_done", 32'(Busy), 0);
    chk("checksum", Checksum, ck_expect(ck));
  endtask

  initial begin
    Rst = 0;
    Start = 1;
    repeat (2) begin
      tick();
      chk_idle("reset");
      chk("reset_addr", Address, 0);
      chk("reset_data", DataOut, 0);
      chk("reset_index", 32'(Word_index), 0);
      chk("reset_checksum", Checksum, 0);
    end
    Rst = 1;
    Start = 0;
    tick();
    chk_idle("idle");

    for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    run_dump(-1, 0, 0, 0, -1);
    repeat (3) begin
      tick();
      chk("done_held", 32'(Done), 1);
      chk("no_read_done", 32'(MemRead), 0);
    end

    run_dump(7, 5, 0, 0, -1);
    run_dump(-1, 0, 0, 1, -1);
    run_dump(-1, 0, 0, 0, 15);
    run_dump(-1, 0, 0, 0, -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      run_dump(-1, 0, 1, 0, -1);
    end

    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0001;
    run_dump(-1, 0, 0, 0, -1);
    chk("checksum_ones", Checksum, ck_expect(32'hFFFF_FFFF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
